// File: rtl/chip8_pkg.sv
// Shared definitions for the Chip8 core.
//   ADDR_W    program address width (PC arithmetic wraps modulo 2**ADDR_W)
//   RESET_PC  PC after reset, the Chip8 program start
//   OPCODE_W  width of an assembled opcode
//   fetch_state_e  fetch FSM states: high byte, low byte, hold for executor
package chip8_pkg;
  localparam int ADDR_W   = 12;
  localparam logic [ADDR_W-1:0] RESET_PC = 12'h200;
  localparam int OPCODE_W = 16;

  typedef enum logic [1:0] {
    S_HI   = 2'd0,
    S_LO   = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch.sv
// Chip8 fetch stage. Reads two bytes at PC from byte-wide memory, packs them
// big-endian into an opcode and offers it on a valid/ready handshake. Owns PC.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mem_req/mem_addr (out)     byte read request, held until mem_ack
//   mem_ack/mem_rdata (in)     read completion and data byte
//   opcode/opcode_valid (out)  assembled opcode offered to executor
//   opcode_ready (in)          executor accepts the opcode
//   pc (out)                   address of the current opcode's first byte
//   pc_load/pc_load_addr (in)  on accept: jump to pc_load_addr
//   pc_skip (in)               on accept: pc+4 (lower priority than load)
module instruction_fetch
  import chip8_pkg::*;
#(
  parameter int ADDR_W = chip8_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = chip8_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [7:0]          mem_rdata,
  output logic [OPCODE_W-1:0] opcode,
  output logic                opcode_valid,
  input  logic                opcode_ready,
  output logic [ADDR_W-1:0]   pc,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_addr,
  input  logic                pc_skip
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [7:0]            hi_q, hi_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  // Low for the first cycle after reset release so the request comes up
  // one clock after release rather than during reset.
  logic                  run_q;
  logic                  ack;

  assign ack = mem_req && mem_ack;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hi_d     = hi_q;
    opcode_d = opcode_q;
    case (state_q)
      S_HI: if (ack) begin
        hi_d    = mem_rdata;
        state_d = S_LO;
      end
      S_LO: if (ack) begin
        opcode_d = {hi_q, mem_rdata};
        state_d  = S_HOLD;
      end
      S_HOLD: if (opcode_ready) begin
        state_d = S_HI;
        if (pc_load)      pc_d = pc_load_addr;
        else if (pc_skip) pc_d = pc_q + ADDR_W'(4);
        else              pc_d = pc_q + ADDR_W'(2);
      end
      default: state_d = S_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HI;
      pc_q     <= RESET_PC;
      hi_q     <= 8'h00;
      opcode_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hi_q     <= hi_d;
      opcode_q <= opcode_d;
      run_q    <= 1'b1;
    end
  end

  // Outputs depend only on registered state; the second byte address wraps.
  assign mem_req      = run_q && (state_q != S_HOLD);
  assign mem_addr     = (state_q == S_LO) ? pc_q + ADDR_W'(1) : pc_q;
  assign opcode_valid = (state_q == S_HOLD);
  assign opcode       = opcode_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_ack;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [15:0] opcode;
  logic        opcode_valid;
  logic        opcode_ready = 1'b0;
  logic [11:0] pc;
  logic        pc_load = 1'b0;
  logic [11:0] pc_load_addr = 12'h000;
  logic        pc_skip = 1'b0;

  int checks = 0;
  int failures = 0;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .opcode(opcode), .opcode_valid(opcode_valid), .opcode_ready(opcode_ready),
    .pc(pc), .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc_skip(pc_skip)
  );

  always #5 clk = ~clk;

  // Byte memory with a programmable number of wait cycles per access.
  logic [7:0] mem [0:4095];
  int ack_delay = 0;
  int wait_cnt;
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk or negedge rst_n)
    if (!rst_n)                 wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                        wait_cnt <= 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the expected PC plus how many bytes of the current opcode have
  // been delivered (0,1,2). Opcode must equal the two memory bytes at PC.
  logic [11:0] exp_pc;
  int          phase;
  logic        prev_wait;
  logic [11:0] prev_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 12'h200; phase = 0; prev_wait = 1'b0; prev_addr = 12'h000;
    end else begin
      logic [11:0] nxt;
      nxt = exp_pc + 12'd1;
      if (prev_wait) begin
        chk("req_held", mem_req, 1'b1);
        chk("addr_held", mem_addr, prev_addr);
      end
      chk("valid_vs_model", opcode_valid, phase == 2);
      chk("req_and_valid", mem_req && opcode_valid, 1'b0);
      if (mem_req) chk("addr_vs_model", mem_addr, (phase == 0) ? exp_pc : nxt);
      if (opcode_valid) begin
        chk("pc_vs_model", pc, exp_pc);
        chk("opcode_vs_model", opcode, {mem[exp_pc], mem[nxt]});
      end
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (mem_req && mem_ack) phase++;
      else if (phase == 2 && opcode_ready) begin
        if (pc_load)      exp_pc = pc_load_addr;
        else if (pc_skip) exp_pc = exp_pc + 12'd4;
        else              exp_pc = exp_pc + 12'd2;
        phase = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!opcode_valid && n < lim) begin tick; n++; end
    chk("valid_timeout", opcode_valid, 1'b1);
  endtask

  // Accept the held opcode with the given controls, then leave junk on the
  // PC controls so a design that honours them outside accept is caught.
  task automatic accept(input logic ld, input logic sk, input logic [11:0] a);
    pc_load = ld; pc_skip = sk; pc_load_addr = a; opcode_ready = 1'b1;
    tick;
    opcode_ready = 1'b0; pc_load = 1'b1; pc_skip = 1'b1; pc_load_addr = 12'h555;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h202] = 8'h56; mem[12'h203] = 8'h78;
    mem[12'h206] = 8'hAB; mem[12'h207] = 8'hCD;
    mem[12'hFFF] = 8'h9A; mem[12'h000] = 8'hBC;

    // Reset and zero-wait first fetch.
    repeat (2) tick;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_opcode", opcode, 16'h0000);
    rst_n = 1'b1;
    chk("rel_req", mem_req, 1'b0);
    chk("rel_addr", mem_addr, 12'h200);
    chk("rel_valid", opcode_valid, 1'b0);
    chk("rel_pc", pc, 12'h200);
    tick;
    chk("t1_req", mem_req, 1'b1);
    chk("t1_addr", mem_addr, 12'h200);
    tick;
    chk("t2_addr", mem_addr, 12'h201);
    chk("t2_valid", opcode_valid, 1'b0);
    tick;
    chk("t3_valid", opcode_valid, 1'b1);
    chk("t3_opcode", opcode, 16'h1234);
    chk("t3_pc", pc, 12'h200);

    // Ready held high: one opcode every 3 cycles.
    opcode_ready = 1'b1;
    tick;
    chk("seq_pc202", pc, 12'h202);
    chk("seq_valid_low", opcode_valid, 1'b0);
    tick; tick;
    chk("seq_valid2", opcode_valid, 1'b1);
    chk("seq_opcode2", opcode, 16'h5678);
    tick; tick; tick;
    chk("seq_valid3", opcode_valid, 1'b1);
    chk("seq_pc204", pc, 12'h204);

    // Two wait cycles per byte, then executor stalls for 4 cycles.
    ack_delay = 2;
    tick;
    opcode_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("slow_addr", mem_addr, (k < 3) ? 12'h206 : 12'h207);
      chk("slow_req", mem_req, 1'b1);
      tick;
    end
    chk("slow_valid", opcode_valid, 1'b1);
    chk("slow_opcode", opcode, 16'hABCD);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("stall_valid", opcode_valid, 1'b1);
      chk("stall_pc", pc, 12'h206);
      chk("stall_opcode", opcode, 16'hABCD);
    end

    // Jump, skip, load-over-skip, wraparound.
    ack_delay = 0;
    accept(1'b1, 1'b0, 12'h210);
    wait_valid(20); chk("jump_pc", pc, 12'h210);
    accept(1'b0, 1'b1, 12'h777);
    chk("skip_addr", mem_addr, 12'h214);
    wait_valid(20); chk("skip_pc", pc, 12'h214);
    accept(1'b1, 1'b1, 12'h300);
    wait_valid(20); chk("load_prio_pc", pc, 12'h300);
    accept(1'b1, 1'b0, 12'hFFE);
    wait_valid(20); chk("pc_ffe", pc, 12'hFFE);
    accept(1'b0, 1'b0, 12'h000);
    wait_valid(20); chk("wrap_pc", pc, 12'h000);
    accept(1'b1, 1'b0, 12'hFFF);
    chk("odd_addr_hi", mem_addr, 12'hFFF);
    tick;
    chk("odd_addr_lo", mem_addr, 12'h000);
    tick;
    chk("odd_opcode", opcode, 16'h9ABC);
    chk("odd_pc", pc, 12'hFFF);

    // Reset while waiting on the low byte.
    accept(1'b0, 1'b0, 12'h000);
    ack_delay = 3;
    for (int k = 0; k < 10 && mem_addr != 12'h002; k++) tick;
    chk("lo_reached", mem_addr, 12'h002);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_valid", opcode_valid, 1'b0);
    chk("mid_rst_opcode", opcode, 16'h0000);
    ack_delay = 0;
    tick; tick;
    rst_n = 1'b1;
    chk("rerel_req", mem_req, 1'b0);
    tick;
    chk("re_addr_hi", mem_addr, 12'h200);
    chk("re_valid1", opcode_valid, 1'b0);
    tick;
    chk("re_addr_lo", mem_addr, 12'h201);
    chk("re_valid2", opcode_valid, 1'b0);
    tick;
    chk("re_valid3", opcode_valid, 1'b1);
    chk("re_opcode", opcode, 16'h1234);
    chk("re_pc", pc, 12'h200);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
